// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared encodings for the byte-serial memory controller
package mem_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } state_t;

  typedef enum logic {
    OWNER_INST = 1'b0,
    OWNER_DATA = 1'b1
  } owner_t;

  // Size code 11 falls through to a full word.
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      SIZE_BYTE: size_bytes = 3'd1;
      SIZE_HALF: size_bytes = 3'd2;
      SIZE_WORD: size_bytes = 3'd4;
      default:   size_bytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_byte_engine.sv
// rtl/mem_byte_engine.sv - byte counter, RAM address stepping and byte capture/emit
module mem_byte_engine #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int RAM_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  load_write,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic [DATA_WIDTH-1:0] load_wdata,
  input  logic [2:0]            load_count,
  input  logic                  step,
  input  logic                  writing,
  input  logic [RAM_WIDTH-1:0]  mem_din,
  output logic [ADDR_WIDTH-1:0] mem_a,
  output logic [RAM_WIDTH-1:0]  mem_dout,
  output logic                  last,
  output logic [DATA_WIDTH-1:0] rd_word
);

  logic [2:0]            cnt;
  logic [2:0]            count;
  logic [DATA_WIDTH-1:0] wbuf;
  logic [DATA_WIDTH-1:0] rbuf;
  logic [1:0]            cap_idx;
  logic [1:0]            last_idx;

  // Read data trails the address by one cycle, so edge k+2 carries byte k.
  assign cap_idx  = cnt[1:0] - 2'd1;
  assign last_idx = count[1:0] - 2'd1;
  assign last     = writing ? (cnt == count - 3'd1) : (cnt == count);

  always_comb begin
    rd_word = rbuf;
    rd_word[RAM_WIDTH*last_idx +: RAM_WIDTH] = mem_din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= 3'd0;
      count    <= 3'd0;
      wbuf     <= '0;
      rbuf     <= '0;
      mem_a    <= '0;
      mem_dout <= '0;
    end else if (load) begin
      cnt   <= 3'd0;
      count <= load_count;
      rbuf  <= '0;
      mem_a <= load_addr;
      if (load_write) begin
        mem_dout <= load_wdata[RAM_WIDTH-1:0];
        wbuf     <= load_wdata >> RAM_WIDTH;
      end
    end else if (step && !last) begin
      cnt <= cnt + 3'd1;
      if (writing) begin
        mem_a    <= mem_a + ADDR_WIDTH'(1);
        mem_dout <= wbuf[RAM_WIDTH-1:0];
        wbuf     <= wbuf >> RAM_WIDTH;
      end else begin
        if (cnt < count - 3'd1) mem_a <= mem_a + ADDR_WIDTH'(1);
        if (cnt != 3'd0) rbuf[RAM_WIDTH*cap_idx +: RAM_WIDTH] <= mem_din;
      end
    end
  end

endmodule

// File: rtl/memory_controller.sv
// rtl/memory_controller.sv - round-robin arbiter serialising fetch and load/store onto a byte RAM
module memory_controller
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int RAM_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  flush,
  input  logic                  inst_req,
  input  logic [ADDR_WIDTH-1:0] inst_addr,
  output logic                  inst_done,
  output logic [DATA_WIDTH-1:0] inst_data,
  input  logic                  data_req,
  input  logic                  data_we,
  input  logic [1:0]            data_size,
  input  logic [ADDR_WIDTH-1:0] data_addr,
  input  logic [DATA_WIDTH-1:0] data_wdata,
  output logic                  data_done,
  output logic [DATA_WIDTH-1:0] data_rdata,
  input  logic [RAM_WIDTH-1:0]  mem_din,
  output logic [RAM_WIDTH-1:0]  mem_dout,
  output logic [ADDR_WIDTH-1:0] mem_a,
  output logic                  mem_wr
);

  state_t                state;
  owner_t                owner;
  owner_t                last_grant;
  logic                  inst_ok;
  logic                  data_ok;
  logic                  grant_data;
  logic                  grant_inst;
  logic                  accept;
  logic                  abort;
  logic                  last;
  logic                  sel_write;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [2:0]            sel_count;
  logic [DATA_WIDTH-1:0] rd_word;

  // A requester still seeing its done pulse is holding a stale request.
  assign inst_ok    = inst_req && !inst_done && !flush;
  assign data_ok    = data_req && !data_done;
  assign grant_data = data_ok && (!inst_ok || last_grant == OWNER_INST);
  assign grant_inst = inst_ok && !grant_data;
  assign accept     = rdy && (state == IDLE) && (grant_inst || grant_data);
  assign abort      = (state == READ) && (owner == OWNER_INST) && flush;
  assign sel_addr   = grant_data ? data_addr : inst_addr;
  assign sel_count  = grant_data ? size_bytes(data_size) : 3'd4;
  assign sel_write  = grant_data && data_we;

  mem_byte_engine #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH),
    .RAM_WIDTH (RAM_WIDTH)
  ) u_engine (
    .clk       (clk),
    .rst       (rst),
    .load      (accept),
    .load_write(sel_write),
    .load_addr (sel_addr),
    .load_wdata(data_wdata),
    .load_count(sel_count),
    .step      (rdy && (state != IDLE) && !abort),
    .writing   (state == WRITE),
    .mem_din   (mem_din),
    .mem_a     (mem_a),
    .mem_dout  (mem_dout),
    .last      (last),
    .rd_word   (rd_word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= OWNER_INST;
      last_grant <= OWNER_INST;
      mem_wr     <= 1'b0;
      inst_done  <= 1'b0;
      data_done  <= 1'b0;
      inst_data  <= '0;
      data_rdata <= '0;
    end else if (rdy) begin
      inst_done <= 1'b0;
      data_done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            owner      <= grant_data ? OWNER_DATA : OWNER_INST;
            last_grant <= grant_data ? OWNER_DATA : OWNER_INST;
            state      <= sel_write ? WRITE : READ;
            mem_wr     <= sel_write;
          end
        end
        READ: begin
          if (abort) begin
            state <= IDLE;
          end else if (last) begin
            state <= IDLE;
            if (owner == OWNER_INST) begin
              inst_done <= 1'b1;
              inst_data <= rd_word;
            end else begin
              data_done  <= 1'b1;
              data_rdata <= rd_word;
            end
          end
        end
        WRITE: begin
          if (last) begin
            state     <= IDLE;
            mem_wr    <= 1'b0;
            data_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
